lsu_arbiter: RTL and testbench

- Shares the single load_store unit (LSU) between two memory requesters.
  - r0: exec_mem, the pipeline load/store path. High priority.
  - r1: a secondary master, such as a page-table walker or debug access. Low priority.
- Sits inside exec, between the requesters and the LSU's prev_stalled/stall_next handshake.
- Sequences one LSU transaction at a time.
- A starvation counter bounds how long r1 waits behind r0.
- r0 transactions can be cancelled by a pipeline flush.

---
 rtl/lsu_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_lsu_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : lsu_arbiter
// Purpose  : Shares the single load/store unit between two requesters and
//            runs one LSU transaction at a time.
//              r0 = pipeline load/store path (high priority, flushable)
//              r1 = secondary master, e.g. page-table walker or debug access
//                   (low priority, never flushed)
//            A saturating starvation counter forces an r1 grant after
//            STARVE_LIMIT consecutive contested r0 grants.
// Ports    : clk, rst_n (async, active low), flush
//            rN_req/addr/is_store/store_data/store_mask  -> request inputs
//            rN_ack, rN_done, rN_load_data, rN_access_fault -> responses
//            lsu_prev_stalled/addr/do_load/do_store/store_data/store_mask
//                                                  -> request to the LSU
//            lsu_stall_next/load_data/access_fault -> result from the LSU
//            busy -> a transaction is in flight (state != IDLE)
// Revision : 1.0 - initial release
// ============================================================================
module lsu_arbiter #(
  parameter int ADDR_W       = 30,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,

  input  logic                r0_req,
  input  logic [ADDR_W-1:0]   r0_addr,
  input  logic                r0_is_store,
  input  logic [DATA_W-1:0]   r0_store_data,
  input  logic [DATA_W/8-1:0] r0_store_mask,
  output logic                r0_ack,
  output logic                r0_done,
  output logic [DATA_W-1:0]   r0_load_data,
  output logic                r0_access_fault,

  input  logic                r1_req,
  input  logic [ADDR_W-1:0]   r1_addr,
  input  logic                r1_is_store,
  input  logic [DATA_W-1:0]   r1_store_data,
  input  logic [DATA_W/8-1:0] r1_store_mask,
  output logic                r1_ack,
  output logic                r1_done,
  output logic [DATA_W-1:0]   r1_load_data,
  output logic                r1_access_fault,

  output logic                lsu_prev_stalled,
  output logic [ADDR_W-1:0]   lsu_addr,
  output logic                lsu_do_load,
  output logic                lsu_do_store,
  output logic [DATA_W-1:0]   lsu_store_data,
  output logic [DATA_W/8-1:0] lsu_store_mask,
  input  logic                lsu_stall_next,
  input  logic [DATA_W-1:0]   lsu_load_data,
  input  logic                lsu_access_fault,

  output logic                busy
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  localparam logic [3:0] C_LIMIT = 4'(STARVE_LIMIT);

  state_t                r_state;
  state_t                w_state_next;
  logic                  r_owner;       // 0 = r0, 1 = r1
  logic                  r_cancel;      // r0 result must be dropped
  logic [3:0]            r_starve_cnt;
  logic [ADDR_W-1:0]     r_addr;
  logic                  r_is_store;
  logic [DATA_W-1:0]     r_store_data;
  logic [DATA_W/8-1:0]   r_store_mask;

  logic                  w_grant0;
  logic                  w_grant1;
  logic                  w_set_cancel;

  // Result data is a straight pass-through; only the done pulses qualify it.
  assign r0_load_data    = lsu_load_data;
  assign r1_load_data    = lsu_load_data;
  assign r0_access_fault = lsu_access_fault;
  assign r1_access_fault = lsu_access_fault;

  assign lsu_addr        = r_addr;
  assign lsu_store_data  = r_store_data;
  assign lsu_store_mask  = r_store_mask;

  assign busy            = (r_state != S_IDLE);

  always_comb begin
    w_state_next     = r_state;
    w_grant0         = 1'b0;
    w_grant1         = 1'b0;
    w_set_cancel     = 1'b0;
    r0_ack           = 1'b0;
    r1_ack           = 1'b0;
    r0_done          = 1'b0;
    r1_done          = 1'b0;
    lsu_prev_stalled = 1'b1;
    lsu_do_load      = 1'b0;
    lsu_do_store     = 1'b0;

    case (r_state)
      S_IDLE: begin
        // r0 yields only when r1 is waiting and has been passed over
        // STARVE_LIMIT times in a row; a flushed r0 request is ignored.
        w_grant0 = r0_req && !flush && !(r1_req && (r_starve_cnt == C_LIMIT));
        w_grant1 = r1_req && !w_grant0;
        r0_ack   = w_grant0;
        r1_ack   = w_grant1;
        if (w_grant0 || w_grant1) begin
          w_state_next = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (flush && !r_owner) begin
          // Flushed before reaching the LSU: drop it without touching the LSU.
          w_state_next = S_IDLE;
        end else begin
          lsu_prev_stalled = 1'b0;
          lsu_do_load      = !r_is_store;
          lsu_do_store     = r_is_store;
          w_state_next     = S_WAIT;
        end
      end

      S_WAIT: begin
        if (!lsu_stall_next) begin
          // The LSU transaction always completes; only the r0 done pulse is
          // suppressed if a flush arrived earlier or arrives right now.
          if (r_owner) begin
            r1_done = 1'b1;
          end else begin
            r0_done = !(r_cancel || flush);
          end
          w_state_next = S_IDLE;
        end else if (flush && !r_owner) begin
          w_set_cancel = 1'b1;
        end
      end

      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_owner      <= 1'b0;
      r_cancel     <= 1'b0;
      r_starve_cnt <= 4'd0;
      r_addr       <= '0;
      r_is_store   <= 1'b0;
      r_store_data <= '0;
      r_store_mask <= '0;
    end else begin
      r_state <= w_state_next;

      if (w_state_next == S_IDLE) begin
        r_cancel <= 1'b0;
      end else if (w_set_cancel) begin
        r_cancel <= 1'b1;
      end

      if (w_grant0) begin
        r_owner      <= 1'b0;
        r_addr       <= r0_addr;
        r_is_store   <= r0_is_store;
        r_store_data <= r0_store_data;
        r_store_mask <= r0_store_mask;
        if (r1_req) begin
          if (r_starve_cnt != C_LIMIT) begin
            r_starve_cnt <= r_starve_cnt + 4'd1;
          end
        end else begin
          r_starve_cnt <= 4'd0;
        end
      end else if (w_grant1) begin
        r_owner      <= 1'b1;
        r_addr       <= r1_addr;
        r_is_store   <= r1_is_store;
        r_store_data <= r1_store_data;
        r_store_mask <= r1_store_mask;
        r_starve_cnt <= 4'd0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lsu_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_lsu_arbiter
// Purpose  : Directed self-checking bench for lsu_arbiter. Inputs change 1ns
//            after the rising edge; outputs are checked on the falling edge.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lsu_arbiter;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;

  logic                clk;
  logic                rst_n;
  logic                flush;
  logic                r0_req, r1_req;
  logic [ADDR_W-1:0]   r0_addr, r1_addr;
  logic                r0_is_store, r1_is_store;
  logic [DATA_W-1:0]   r0_store_data, r1_store_data;
  logic [DATA_W/8-1:0] r0_store_mask, r1_store_mask;
  logic                r0_ack, r1_ack, r0_done, r1_done;
  logic [DATA_W-1:0]   r0_load_data, r1_load_data;
  logic                r0_access_fault, r1_access_fault;
  logic                lsu_prev_stalled, lsu_do_load, lsu_do_store;
  logic [ADDR_W-1:0]   lsu_addr;
  logic [DATA_W-1:0]   lsu_store_data;
  logic [DATA_W/8-1:0] lsu_store_mask;
  logic                lsu_stall_next;
  logic [DATA_W-1:0]   lsu_load_data;
  logic                lsu_access_fault;
  logic                busy;

  int checks = 0;
  int errors = 0;

  lsu_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_LIMIT(4)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .r0_req(r0_req), .r0_addr(r0_addr), .r0_is_store(r0_is_store),
    .r0_store_data(r0_store_data), .r0_store_mask(r0_store_mask),
    .r0_ack(r0_ack), .r0_done(r0_done), .r0_load_data(r0_load_data),
    .r0_access_fault(r0_access_fault),
    .r1_req(r1_req), .r1_addr(r1_addr), .r1_is_store(r1_is_store),
    .r1_store_data(r1_store_data), .r1_store_mask(r1_store_mask),
    .r1_ack(r1_ack), .r1_done(r1_done), .r1_load_data(r1_load_data),
    .r1_access_fault(r1_access_fault),
    .lsu_prev_stalled(lsu_prev_stalled), .lsu_addr(lsu_addr),
    .lsu_do_load(lsu_do_load), .lsu_do_store(lsu_do_store),
    .lsu_store_data(lsu_store_data), .lsu_store_mask(lsu_store_mask),
    .lsu_stall_next(lsu_stall_next), .lsu_load_data(lsu_load_data),
    .lsu_access_fault(lsu_access_fault), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  // Expected grant order with both requesters held high: 1 = r1 wins.
  logic [9:0] grant_r1;

  initial begin
    grant_r1 = 10'b1000010000; // bit k = grant k; r1 wins at k = 4 and k = 9

    rst_n = 1'b0; flush = 1'b0;
    r0_req = 1'b0; r0_addr = '0; r0_is_store = 1'b0; r0_store_data = '0; r0_store_mask = '0;
    r1_req = 1'b0; r1_addr = '0; r1_is_store = 1'b0; r1_store_data = '0; r1_store_mask = '0;
    lsu_stall_next = 1'b1; lsu_load_data = '0; lsu_access_fault = 1'b0;

    // ---------------- reset state ----------------
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_prev_stalled", lsu_prev_stalled, 1);
    chk("rst_do_load", lsu_do_load, 0);
    chk("rst_do_store", lsu_do_store, 0);
    chk("rst_acks", {r0_ack, r1_ack}, 0);
    chk("rst_dones", {r0_done, r1_done}, 0);
    tick();
    rst_n = 1'b1;

    // ---------------- r0 load ----------------
    tick();
    r0_req = 1'b1; r0_addr = 30'h40; r0_is_store = 1'b0;
    settle();
    chk("t1_r0_ack", r0_ack, 1);
    chk("t1_r1_ack", r1_ack, 0);
    tick();
    r0_req = 1'b0;
    settle();
    chk("t1_prev_stalled", lsu_prev_stalled, 0);
    chk("t1_do_load", lsu_do_load, 1);
    chk("t1_do_store", lsu_do_store, 0);
    chk("t1_addr", lsu_addr, 30'h40);
    chk("t1_busy", busy, 1);
    tick();
    lsu_stall_next = 1'b0; lsu_load_data = 32'hDEAD;
    settle();
    chk("t1_r0_done", r0_done, 1);
    chk("t1_r0_data", r0_load_data, 32'hDEAD);
    chk("t1_r1_done", r1_done, 0);
    chk("t1_wait_load", lsu_do_load, 0);
    tick();
    lsu_stall_next = 1'b1;
    settle();
    chk("t1_busy_end", busy, 0);
    chk("t1_done_end", r0_done, 0);

    // ---------------- starvation ----------------
    tick();
    r0_req = 1'b1; r0_addr = 30'h100; r0_is_store = 1'b0;
    r1_req = 1'b1; r1_addr = 30'h200; r1_is_store = 1'b0;
    lsu_stall_next = 1'b0;
    for (int k = 0; k < 10; k++) begin
      settle();
      chk("st_r0_ack", r0_ack, !grant_r1[k]);
      chk("st_r1_ack", r1_ack, grant_r1[k]);
      tick();
      settle();
      chk("st_issue", lsu_prev_stalled, 0);
      chk("st_issue_addr", lsu_addr, grant_r1[k] ? 30'h200 : 30'h100);
      tick();
      settle();
      chk("st_r0_done", r0_done, !grant_r1[k]);
      chk("st_r1_done", r1_done, grant_r1[k]);
      tick();
    end
    r0_req = 1'b0; r1_req = 1'b0; lsu_stall_next = 1'b1;

    // ---------------- r1 store with 5 stall cycles and fault ----------------
    r1_req = 1'b1; r1_addr = 30'h80; r1_is_store = 1'b1;
    r1_store_data = 32'h12345678; r1_store_mask = 4'hF;
    settle();
    chk("t3_r1_ack", r1_ack, 1);
    tick();
    r1_req = 1'b0;
    settle();
    chk("t3_do_store", lsu_do_store, 1);
    chk("t3_do_load", lsu_do_load, 0);
    chk("t3_mask", lsu_store_mask, 4'hF);
    chk("t3_data", lsu_store_data, 32'h12345678);
    for (int i = 0; i < 5; i++) begin
      tick();
      settle();
      chk("t3_stall_store", lsu_do_store, 0);
      chk("t3_stall_done", r1_done, 0);
    end
    tick();
    lsu_stall_next = 1'b0; lsu_access_fault = 1'b1;
    settle();
    chk("t3_r1_done", r1_done, 1);
    chk("t3_fault", r1_access_fault, 1);
    chk("t3_r0_done", r0_done, 0);
    tick();
    lsu_stall_next = 1'b1; lsu_access_fault = 1'b0;

    // ---------------- flush in r0 ISSUE ----------------
    r0_req = 1'b1; r0_addr = 30'h44; r0_is_store = 1'b0;
    settle();
    chk("f1_ack", r0_ack, 1);
    tick();
    r0_req = 1'b0; flush = 1'b1;
    settle();
    chk("f1_prev_stalled", lsu_prev_stalled, 1);
    chk("f1_do_load", lsu_do_load, 0);
    tick();
    flush = 1'b0;
    settle();
    chk("f1_busy", busy, 0);
    chk("f1_done", r0_done, 0);

    // ---------------- flush in r0 WAIT ----------------
    tick();
    r0_req = 1'b1;
    settle();
    chk("f2_ack", r0_ack, 1);
    tick();
    r0_req = 1'b0;
    settle();
    chk("f2_do_load", lsu_do_load, 1);
    tick();
    flush = 1'b1;
    settle();
    chk("f2_done_a", r0_done, 0);
    tick();
    flush = 1'b0; lsu_stall_next = 1'b0;
    settle();
    chk("f2_done_b", r0_done, 0);
    chk("f2_busy", busy, 1);
    tick();
    lsu_stall_next = 1'b1;
    settle();
    chk("f2_idle", busy, 0);

    // ---------------- flush on the completion cycle ----------------
    tick();
    r0_req = 1'b1;
    settle();
    chk("f3_ack", r0_ack, 1);
    tick();
    r0_req = 1'b0;
    tick();
    flush = 1'b1; lsu_stall_next = 1'b0;
    settle();
    chk("f3_done", r0_done, 0);
    tick();
    flush = 1'b0; lsu_stall_next = 1'b1;
    settle();
    chk("f3_idle", busy, 0);

    // ------- flush in IDLE lets r1 win; flush during r1 WAIT is ignored -------
    tick();
    flush = 1'b1; r0_req = 1'b1; r1_req = 1'b1; r1_is_store = 1'b0;
    settle();
    chk("f4_r0_ack", r0_ack, 0);
    chk("f4_r1_ack", r1_ack, 1);
    tick();
    flush = 1'b0; r1_req = 1'b0;
    settle();
    chk("f4_busy_no_ack", r0_ack, 0);
    chk("f4_do_load", lsu_do_load, 1);
    tick();
    flush = 1'b1; lsu_stall_next = 1'b0; lsu_load_data = 32'hBEEF;
    settle();
    chk("f4_r1_done", r1_done, 1);
    chk("f4_r1_data", r1_load_data, 32'hBEEF);
    chk("f4_r0_done", r0_done, 0);
    tick();
    flush = 1'b0; lsu_stall_next = 1'b1;
    settle();
    chk("f4_r0_ack_late", r0_ack, 1);
    tick();
    r0_req = 1'b0;
    tick();
    lsu_stall_next = 1'b0;
    settle();
    chk("f4_r0_done_late", r0_done, 1);
    tick();
    lsu_stall_next = 1'b1;

    // ---------------- reset during WAIT ----------------
    r0_req = 1'b1; r0_addr = 30'h48;
    settle();
    chk("r_ack", r0_ack, 1);
    tick();
    r0_req = 1'b0;
    tick();
    settle();
    chk("r_busy_wait", busy, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("r_busy_rst", busy, 0);
    chk("r_prev_stalled_rst", lsu_prev_stalled, 1);
    chk("r_strobes_rst", {lsu_do_load, lsu_do_store}, 0);
    chk("r_dones_rst", {r0_done, r1_done}, 0);
    lsu_stall_next = 1'b0;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      settle();
      chk("r_no_done", {r0_done, r1_done}, 0);
      chk("r_idle", busy, 0);
      tick();
    end
    lsu_stall_next = 1'b1;
    r0_req = 1'b1; r0_addr = 30'h4C;
    settle();
    chk("r_fresh_ack", r0_ack, 1);
    tick();
    r0_req = 1'b0;
    settle();
    chk("r_fresh_addr", lsu_addr, 30'h4C);
    tick();
    lsu_stall_next = 1'b0;
    settle();
    chk("r_fresh_done", r0_done, 1);
    tick();
    lsu_stall_next = 1'b1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
